// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bundle between the ID/EX register and the EX-stage RV32M mul/div unit.
// master drives the operation request, slave is the unit itself.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  // Start is a request strobe. It is taken only when the unit is in IDLE or DONE
  // and Flush is low; Stall is the ready-inverse the pipeline holds on. Done pulses
  // for exactly one cycle when Result is valid. Result then holds until the next
  // accepted Start.
  logic            Start;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] rs1val;
  logic [XLEN-1:0] rs2val;
  logic            Flush;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;
  logic            Stall;

  modport master (
    output Start, Funct3, rs1val, rs2val, Flush,
    input  Busy, Done, Result, Stall
  );

  modport slave (
    input  Start, Funct3, rs1val, rs2val, Flush,
    output Busy, Done, Result, Stall
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Optional macro MULDIV_FAST_MUL_EN computes multiplies with a single-cycle 33x33 multiplier.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic               CLK,
  input  logic               RST,
  ex_muldiv_unit_if.slave    bus,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [2:0]          f3;
  logic [XLEN-1:0]     op_a;
  logic [XLEN-1:0]     op_b;
  logic [2*XLEN-1:0]   acc;
  logic [4:0]          cnt;
  logic                neg_a;
  logic                neg_b;
  logic                raw_res;
  logic [XLEN-1:0]     result_q;

  logic                accept;
  logic                is_mul;
  logic                sgn_a;
  logic                sgn_b;
  logic                a_neg;
  logic                b_neg;
  logic [XLEN-1:0]     a_abs;
  logic [XLEN-1:0]     b_abs;
  logic                div_zero;
  logic                div_ovf;
  logic                fast_mul;
  logic                skip_calc;
  logic [2*XLEN-1:0]   fast_prod;

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_shift;
  logic [XLEN+1:0]     div_diff;
  logic [XLEN-1:0]     rem_new;
  logic [2*XLEN-1:0]   div_next;

  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix;
  logic [XLEN-1:0]     rem_fix;
  logic [XLEN-1:0]     fix_res;

  assign accept = bus.Start & ~bus.Flush & ((state == S_IDLE) | (state == S_DONE));

  // Operation decode works on the latched funct3, never on the live input.
  assign is_mul = ~f3[2];
  assign sgn_a  = (f3 == 3'b001) | (f3 == 3'b010) | (f3 == 3'b100) | (f3 == 3'b110);
  assign sgn_b  = (f3 == 3'b001) | (f3 == 3'b100) | (f3 == 3'b110);
  assign a_neg  = sgn_a & op_a[XLEN-1];
  assign b_neg  = sgn_b & op_b[XLEN-1];
  assign a_abs  = a_neg ? -op_a : op_a;
  assign b_abs  = b_neg ? -op_b : op_b;

  assign div_zero = ~is_mul & (op_b == '0);
  assign div_ovf  = ~is_mul & ~f3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a;
  logic signed [2*XLEN-1:0] fast_b;
  // 33x33 signed multiply; sign-extension to 64 bits keeps the low 64 product bits exact.
  assign fast_a    = {{XLEN{a_neg}}, op_a};
  assign fast_b    = {{XLEN{b_neg}}, op_b};
  assign fast_prod = fast_a * fast_b;
  assign fast_mul  = is_mul;
`else
  assign fast_prod = '0;
  assign fast_mul  = 1'b0;
`endif

  assign skip_calc = div_zero | div_ovf | fast_mul;

  // Shift-add step: acc = {partial high word, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_a} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide step: acc = {partial remainder, dividend/quotient shifter}.
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, op_b};
  assign rem_new   = div_diff[XLEN+1] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
  assign div_next  = {rem_new, acc[XLEN-2:0], ~div_diff[XLEN+1]};

  // Sign fix-up; raw_res marks results that are already final (special cases, fast multiply).
  assign prod_fix = (~raw_res & (neg_a ^ neg_b)) ? -acc : acc;
  assign quo_fix  = (~raw_res & (neg_a ^ neg_b)) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = (~raw_res & neg_a) ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    if (is_mul) begin
      fix_res = (f3[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end else begin
      fix_res = f3[1] ? rem_fix : quo_fix;
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; Flush overrides every transition.
  always_comb begin
    state_nxt = state;
    if (bus.Flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.Start) state_nxt = S_PREP;
        S_PREP:  state_nxt = skip_calc ? S_FIX : S_CALC;
        S_CALC:  if (cnt == 5'd31) state_nxt = S_FIX;
        S_FIX:   state_nxt = S_DONE;
        S_DONE:  state_nxt = bus.Start ? S_PREP : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    bus.Busy  = 1'b0;
    bus.Done  = 1'b0;
    dbg_state = state;
    case (state)
      S_PREP, S_CALC, S_FIX: bus.Busy = 1'b1;
      S_DONE:                bus.Done = 1'b1;
      default:               ;
    endcase
  end

  assign bus.Stall  = bus.Busy | (bus.Start & ((state == S_IDLE) | (state == S_DONE)));
  assign bus.Result = result_q;

  // Datapath; a flushed cycle leaves every register untouched.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      f3       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      raw_res  <= 1'b0;
      result_q <= '0;
    end else if (!bus.Flush) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            f3   <= bus.Funct3;
            op_a <= bus.rs1val;
            op_b <= bus.rs2val;
          end
        end
        S_PREP: begin
          neg_a   <= a_neg;
          neg_b   <= b_neg;
          cnt     <= '0;
          raw_res <= skip_calc;
          op_a    <= a_abs;
          op_b    <= b_abs;
          if (div_zero) begin
            acc <= {op_a, {XLEN{1'b1}}};
          end else if (div_ovf) begin
            acc <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
          end else if (fast_mul) begin
            acc <= fast_prod;
          end else if (is_mul) begin
            acc <= {{XLEN{1'b0}}, b_abs};
          end else begin
            acc <= {{XLEN{1'b0}}, a_abs};
          end
        end
        S_CALC: begin
          acc <= is_mul ? mul_next : div_next;
          cnt <= cnt + 5'd1;
        end
        S_FIX: begin
          result_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed RV32M vectors, special cases,
// flush, ignored Start, back-to-back Start in DONE and asynchronous reset mid-operation.
module tb_ex_muldiv_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] dbg_state;

  ex_muldiv_unit_if #(.XLEN(32)) bus ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge after the edge that accepted Start.
  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    bus.Start  = 1'b1;
    bus.Funct3 = f3;
    bus.rs1val = a;
    bus.rs2val = b;
    exp_q.push_back(exp);
    #1 check("stall_at_start", {31'b0, bus.Stall}, 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    bus.Start  = 1'b0;
    bus.Funct3 = 3'($urandom_range(0, 7));
    bus.rs1val = $urandom;
    bus.rs2val = $urandom;
  endtask

  // Counts edges after the accepting edge until Done; poke>0 pulses a stray Start then.
  task automatic wait_done(input string tag, input int lat, input int poke);
    int          seen;
    bit          stall_ok;
    logic [31:0] exp;
    seen     = 0;
    stall_ok = (bus.Stall === 1'b1);
    for (int i = 1; i <= 60 && seen == 0; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (poke > 0 && i == poke + 1) bus.Start = 1'b0;
      if (bus.Done === 1'b1) seen = i;
      else if (bus.Stall !== 1'b1) stall_ok = 1'b0;
      if (poke > 0 && i == poke && seen == 0) begin
        bus.Start  = 1'b1;
        bus.Funct3 = 3'b000;
        bus.rs1val = 32'h0000_1234;
        bus.rs2val = 32'h0000_5678;
      end
    end
    bus.Start = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_latency"}, seen, lat);
    check({tag, "_result"}, bus.Result, exp);
    check({tag, "_stall"}, {31'b0, stall_ok}, 32'd1);
  endtask

  localparam int NV = 16;
  logic [2:0]  v_f3 [NV];
  logic [31:0] v_a  [NV];
  logic [31:0] v_b  [NV];
  logic [31:0] v_r  [NV];
  int          v_l  [NV];

  initial begin
    v_f3[0]  = 3'b000; v_a[0]  = 32'h0000_0007; v_b[0]  = 32'hFFFF_FFFD; v_r[0]  = 32'hFFFF_FFEB; v_l[0]  = MUL_LAT;
    v_f3[1]  = 3'b001; v_a[1]  = 32'h8000_0000; v_b[1]  = 32'h8000_0000; v_r[1]  = 32'h4000_0000; v_l[1]  = MUL_LAT;
    v_f3[2]  = 3'b011; v_a[2]  = 32'hFFFF_FFFF; v_b[2]  = 32'hFFFF_FFFF; v_r[2]  = 32'hFFFF_FFFE; v_l[2]  = MUL_LAT;
    v_f3[3]  = 3'b010; v_a[3]  = 32'hFFFF_FFFF; v_b[3]  = 32'hFFFF_FFFF; v_r[3]  = 32'hFFFF_FFFF; v_l[3]  = MUL_LAT;
    v_f3[4]  = 3'b100; v_a[4]  = 32'hFFFF_FFF9; v_b[4]  = 32'h0000_0002; v_r[4]  = 32'hFFFF_FFFD; v_l[4]  = 34;
    v_f3[5]  = 3'b110; v_a[5]  = 32'hFFFF_FFF9; v_b[5]  = 32'h0000_0002; v_r[5]  = 32'hFFFF_FFFF; v_l[5]  = 34;
    v_f3[6]  = 3'b101; v_a[6]  = 32'd100;       v_b[6]  = 32'd7;         v_r[6]  = 32'd14;        v_l[6]  = 34;
    v_f3[7]  = 3'b111; v_a[7]  = 32'd100;       v_b[7]  = 32'd7;         v_r[7]  = 32'd2;         v_l[7]  = 34;
    v_f3[8]  = 3'b101; v_a[8]  = 32'd5;         v_b[8]  = 32'd0;         v_r[8]  = 32'hFFFF_FFFF; v_l[8]  = 2;
    v_f3[9]  = 3'b110; v_a[9]  = 32'd5;         v_b[9]  = 32'd0;         v_r[9]  = 32'd5;         v_l[9]  = 2;
    v_f3[10] = 3'b100; v_a[10] = 32'h8000_0000; v_b[10] = 32'hFFFF_FFFF; v_r[10] = 32'h8000_0000; v_l[10] = 2;
    v_f3[11] = 3'b110; v_a[11] = 32'h8000_0000; v_b[11] = 32'hFFFF_FFFF; v_r[11] = 32'h0000_0000; v_l[11] = 2;
    v_f3[12] = 3'b111; v_a[12] = 32'h8000_0000; v_b[12] = 32'hFFFF_FFFF; v_r[12] = 32'h8000_0000; v_l[12] = 34;
    v_f3[13] = 3'b100; v_a[13] = 32'hFFFF_FFFB; v_b[13] = 32'd0;         v_r[13] = 32'hFFFF_FFFF; v_l[13] = 2;
    v_f3[14] = 3'b110; v_a[14] = 32'hFFFF_FFFB; v_b[14] = 32'd0;         v_r[14] = 32'hFFFF_FFFB; v_l[14] = 2;
    v_f3[15] = 3'b000; v_a[15] = 32'hFFFF_FFFF; v_b[15] = 32'hFFFF_FFFF; v_r[15] = 32'h0000_0001; v_l[15] = MUL_LAT;
  end

  initial begin
    bit quiet;
    RST        = 1'b1;
    bus.Start  = 1'b0;
    bus.Flush  = 1'b0;
    bus.Funct3 = 3'b000;
    bus.rs1val = '0;
    bus.rs2val = '0;

    // Reset state
    #12;
    check("rst_state",  {29'b0, dbg_state}, 32'd0);
    check("rst_busy",   {31'b0, bus.Busy},  32'd0);
    check("rst_done",   {31'b0, bus.Done},  32'd0);
    check("rst_result", bus.Result,         32'd0);
    check("rst_stall",  {31'b0, bus.Stall}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      drive_op(v_f3[i], v_a[i], v_b[i], v_r[i]);
      wait_done($sformatf("vec%0d", i), v_l[i], 0);
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("vec%0d_done_pulse", i), {31'b0, bus.Done}, 32'd0);
    end

    // Stray Start during CALC must not disturb the running divide
    drive_op(3'b101, 32'h0000_FFFF, 32'h0000_0010, 32'h0000_0FFF);
    wait_done("ignore_start", 34, 15);
    @(posedge CLK);
    @(negedge CLK);

    // Establish Result=14, then flush a divide at CALC counter 10
    drive_op(3'b101, 32'd100, 32'd7, 32'd14);
    wait_done("pre_flush", 34, 0);
    @(posedge CLK);
    @(negedge CLK);
    drive_op(3'b101, 32'h0000_FFFF, 32'd3, 32'h0000_5555);
    void'(exp_q.pop_back());
    quiet = 1'b1;
    repeat (11) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.Done !== 1'b0) quiet = 1'b0;
    end
    check("flush_in_calc", {29'b0, dbg_state}, 32'd2);
    bus.Flush  = 1'b1;
    bus.Start  = 1'b1;
    bus.Funct3 = 3'b000;
    bus.rs1val = 32'd3;
    bus.rs2val = 32'd3;
    @(posedge CLK);
    @(negedge CLK);
    bus.Flush = 1'b0;
    bus.Start = 1'b0;
    #1;
    check("flush_state",  {29'b0, dbg_state}, 32'd0);
    check("flush_busy",   {31'b0, bus.Busy},  32'd0);
    check("flush_stall",  {31'b0, bus.Stall}, 32'd0);
    check("flush_result", bus.Result,         32'd14);
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.Done !== 1'b0 || dbg_state !== 3'd0) quiet = 1'b0;
    end
    check("flush_no_done", {31'b0, quiet}, 32'd1);

    // Fresh op after flush, then back-to-back Start accepted in DONE
    drive_op(3'b101, 32'd1000, 32'd3, 32'd333);
    wait_done("after_flush", 34, 0);
    drive_op(3'b111, 32'd1000, 32'd3, 32'd1);
    wait_done("back_to_back", 34, 0);
    @(posedge CLK);
    @(negedge CLK);

    // Asynchronous reset mid-CALC
    drive_op(3'b101, 32'd77, 32'd5, 32'd15);
    repeat (8) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    check("rst_mid_in_calc", {29'b0, dbg_state}, 32'd2);
    RST = 1'b1;
    #1;
    check("rst_mid_busy",   {31'b0, bus.Busy},  32'd0);
    check("rst_mid_result", bus.Result,         32'd0);
    check("rst_mid_state",  {29'b0, dbg_state}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    quiet = 1'b1;
    repeat (40) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.Done !== 1'b0) quiet = 1'b0;
    end
    check("rst_mid_no_done", {31'b0, quiet}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered rs1val/rs2val and a funct3 opcode. Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Drives Stall so the IF/ID and ID/EX registers hold until Result is valid.
- Result feeds the EX/MEM register's ALU-result mux.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous, active-high reset
Start  input  1  launch operation; sampled only in IDLE or DONE
Funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1val  input  32  operand A / dividend
rs2val  input  32  operand B / divisor
Flush  input  1  synchronous abort (branch mispredict / trap)
Busy  output  1  high in PREP, CALC, FIX
Done  output  1  one-cycle pulse, Result valid
Result  output  32  registered result, held until next accepted Start
Stall  output  1  combinational: Busy | (Start & (state==IDLE | state==DONE))

Behaviour:
- Reset (async, immediate): state=IDLE, Busy=0, Done=0, Result=0, iteration counter=0, internal operand/accumulator registers=0.
- FSM: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
  - Start is accepted in IDLE or DONE (DONE->PREP allows back-to-back ops).
  - Start in PREP/CALC/FIX is ignored.
- Edge N samples Start: latch Funct3, rs1val, rs2val. Later input changes have no effect.
- PREP (1 cycle):
  - Record operand signs per op; signed for MULH, DIV, REM; rs1 only for MULHSU.
  - Take absolute values into 32-bit unsigned working registers.
  - Detect special cases:
    - Divisor==0: quotient=0xFFFFFFFF, remainder=dividend.
    - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
  - Special cases go PREP->FIX, skipping CALC.
- CALC (exactly 32 cycles, counter 0..31):
  - Multiply: shift-add producing a 64-bit unsigned product.
  - Divide: restoring, one quotient bit per cycle.
  - Counter==31 -> FIX.
- FIX (1 cycle):
  - Product: negate 64-bit product if signs differ. MUL takes the low word; MULH/MULHSU/MULHU take the high word.
  - Quotient: negate if signs differ. Remainder: takes the sign of the dividend.
  - Write Result.
- DONE (1 cycle): Done=1, then IDLE unless Start is accepted.
- Latency:
  - Normal: Done high in the cycle after edge N+34.
  - Special-case divide: Done high after edge N+2.
- Flush: takes priority over all state transitions.
  - Next edge -> IDLE. Done is not asserted; Result is unchanged.
  - Start coincident with Flush is ignored.
- Reset mid-operation: abort immediately; no Done.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - Multiply ops compute the full 64-bit product in PREP using a single-cycle signed 33x33 multiplier (operands sign/zero-extended per op), then go PREP->FIX.
  - MUL* Done high after edge N+2.
  - Divide path unchanged.
- Undefined: multiplies use the 32-cycle iterative CALC path. No hardware multiplier is inferred.

Test Plan:
- MUL rs1=0x00000007, rs2=0xFFFFFFFD -> Result=0xFFFFFFEB, Done one cycle after edge N+34 (N+2 with MULDIV_FAST_MUL_EN); Stall high from the Start cycle through the cycle before Done.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
  - Each Done after edge N+2.
- Flush at CALC counter=10 of DIVU (previous Result=14):
  - IDLE next edge; Done never pulses; Result stays 14; Stall drops.
  - New Start the following cycle completes normally.
- Interrupted and back-to-back operation:
  - Start pulsed during CALC with different operands: ignored, original op completes.
  - RST asserted mid-CALC: Busy=0, Result=0 without waiting for a clock edge.
  - Start during DONE: accepted, next Done after edge +34.
